// File: rtl/seq_div_unit_if.sv
// Start/done handshake between the execute stage and the multi-cycle divider.
// The master side belongs to execute; the divider is the slave.
interface seq_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            abort_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic [2:0]      op_type_i;
  logic [XLEN-1:0] result_o;
  logic            done_o;
  logic            busy_o;

  modport master (
    output start_i, abort_i, operand_a_i, operand_b_i, op_type_i,
    input  result_o, done_o, busy_o
  );

  modport slave (
    input  start_i, abort_i, operand_a_i, operand_b_i, op_type_i,
    output result_o, done_o, busy_o
  );
endinterface

// File: rtl/seq_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring loop, one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced on a short path.
module seq_div_unit #(
  parameter int XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_ni,
  seq_div_unit_if.slave div_if
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_r, state_s;
  logic [XLEN-1:0]  dvd_r;      // dividend magnitude, quotient bits shift in at the LSB
  logic [XLEN-1:0]  dvs_r;
  logic [XLEN-1:0]  rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r, neg_r_r, is_rem_r;
  logic [XLEN-1:0]  result_r;
  logic             done_r, busy_r;

  logic             uns_s, rem_op_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]  abs_a_s, abs_b_s, spec_res_s;
  logic             div_zero_s, ovf_s, special_s;
  logic [XLEN:0]    rem_shift_s, diff_s;
  logic             qbit_s;
  logic [XLEN-1:0]  quot_fix_s, rem_fix_s, res_fix_s;

  // Operand decode, special-case detection, one restoring step and final sign fix.
  always_comb begin
    uns_s      = div_if.op_type_i[0];
    rem_op_s   = div_if.op_type_i[1];
    a_neg_s    = ~uns_s & div_if.operand_a_i[XLEN-1];
    b_neg_s    = ~uns_s & div_if.operand_b_i[XLEN-1];
    abs_a_s    = a_neg_s ? (ZERO - div_if.operand_a_i) : div_if.operand_a_i;
    abs_b_s    = b_neg_s ? (ZERO - div_if.operand_b_i) : div_if.operand_b_i;
    div_zero_s = (div_if.operand_b_i == ZERO);
    ovf_s      = ~uns_s & (div_if.operand_a_i == MIN_NEG) & (div_if.operand_b_i == ALL_ONES);
    special_s  = div_zero_s | ovf_s;
    if (div_zero_s) begin
      spec_res_s = rem_op_s ? div_if.operand_a_i : ALL_ONES;
    end else if (ovf_s) begin
      spec_res_s = rem_op_s ? ZERO : MIN_NEG;
    end else begin
      spec_res_s = ZERO;
    end

    rem_shift_s = {rem_r, dvd_r[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    qbit_s      = ~diff_s[XLEN];

    quot_fix_s = neg_q_r ? (ZERO - dvd_r) : dvd_r;
    rem_fix_s  = neg_r_r ? (ZERO - rem_r) : rem_r;
    res_fix_s  = is_rem_r ? rem_fix_s : quot_fix_s;
  end

  // Next-state logic; special results skip the loop and pass through FIXUP.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (div_if.abort_i) begin
          state_s = IDLE;
        end else if (div_if.start_i) begin
          state_s = special_s ? FIXUP : DIVIDE;
        end else begin
          state_s = IDLE;
        end
      end
      DIVIDE: begin
        if (div_if.abort_i) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          state_s = FIXUP;
        end else begin
          state_s = DIVIDE;
        end
      end
      FIXUP: begin
        if (div_if.abort_i) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      dvd_r    <= ZERO;
      dvs_r    <= ZERO;
      rem_r    <= ZERO;
      cnt_r    <= {CNT_W{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_rem_r <= 1'b0;
      result_r <= ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_r == FIXUP) && !div_if.abort_i;
      busy_r  <= (state_s != IDLE);
      if ((state_r == IDLE) && (state_s != IDLE)) begin
        rem_r <= ZERO;
        cnt_r <= CNT_W'(XLEN);
        dvs_r <= abs_b_s;
        if (special_s) begin
          // Preload the final value so FIXUP passes it through untouched.
          dvd_r    <= spec_res_s;
          neg_q_r  <= 1'b0;
          neg_r_r  <= 1'b0;
          is_rem_r <= 1'b0;
        end else begin
          dvd_r    <= abs_a_s;
          neg_q_r  <= a_neg_s ^ b_neg_s;
          neg_r_r  <= a_neg_s;
          is_rem_r <= rem_op_s;
        end
      end else if (state_r == DIVIDE) begin
        rem_r <= qbit_s ? diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
        dvd_r <= {dvd_r[XLEN-2:0], qbit_s};
        cnt_r <= cnt_r - CNT_W'(1);
      end else if ((state_r == FIXUP) && !div_if.abort_i) begin
        result_r <= res_fix_s;
      end
    end
  end

  assign div_if.result_o = result_r;
  assign div_if.done_o   = done_r;
  assign div_if.busy_o   = busy_r;

endmodule
